// File: rtl/sub32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sub32_pkg                                                            |
// | Shared sizing constants and FSM encoding for the serial subtractor.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sub32_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cla8_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla8_slice                                                           |
// | Combinational 8-bit generate/propagate carry-lookahead adder slice.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cla8_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_c[0] = ci;

  // Each carry is a flat sum of products over all lower generate terms.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_carry
      logic w_acc;
      logic w_pp;

      always_comb begin
        w_acc = w_g[i];
        w_pp  = w_p[i];
        for (int j = i - 1; j >= 0; j--) begin
          w_acc = w_acc | (w_pp & w_g[j]);
          w_pp  = w_pp & w_p[j];
        end
        w_acc = w_acc | (w_pp & ci);
      end

      assign w_c[i+1] = w_acc;
    end
  endgenerate

  assign s  = w_p ^ w_c[7:0];
  assign co = w_c[8];

endmodule
`default_nettype wire

// File: rtl/sub32_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sub32_serial                                                         |
// | Multi-cycle A - B - Bin through one reused 8-bit CLA slice, LSB first|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sub32_serial #(
  parameter int WIDTH = sub32_pkg::WIDTH,
  parameter int SLICE = sub32_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  import sub32_pkg::*;

  localparam int c_nslice = WIDTH / SLICE;
  localparam int c_idx_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [c_idx_w-1:0] r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c;
  logic [WIDTH-1:0]   r_shadow;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;
  logic               r_ovf;
  logic               r_done;

  logic [SLICE-1:0]   w_a_byte;
  logic [SLICE-1:0]   w_nb_byte;
  logic [SLICE-1:0]   w_s;
  logic               w_co;
  logic               w_last;
  logic [WIDTH-1:0]   w_full;

  // Byte mux; the subtrahend byte is inverted here so the slice only adds.
  always_comb begin
    w_a_byte  = '0;
    w_nb_byte = '0;
    for (int k = 0; k < c_nslice; k++) begin
      if (r_idx == c_idx_w'(k)) begin
        w_a_byte  = r_a[k*SLICE +: SLICE];
        w_nb_byte = ~r_b[k*SLICE +: SLICE];
      end
    end
  end

  cla8_slice u_slice (
    .a  (w_a_byte),
    .b  (w_nb_byte),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_idx == c_idx_w'(c_nslice - 1));

  // Completed result: shadow bytes below plus the top byte being produced now.
  always_comb begin
    w_full                  = r_shadow;
    w_full[WIDTH-1 -: SLICE] = w_s;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_shadow <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= ~bin;
            r_idx <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < c_nslice; k++) begin
            if (r_idx == c_idx_w'(k)) begin
              r_shadow[k*SLICE +: SLICE] <= w_s;
            end
          end
          r_c   <= w_co;
          r_idx <= r_idx + c_idx_w'(1);
          if (w_last) begin
            r_idx  <= '0;
            r_d    <= w_full;
            r_bout <= ~w_co;
            r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_full[WIDTH-1] ^ r_a[WIDTH-1]);
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sub32_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sub32_serial                                                      |
// | Directed-vector and corner-sequence bench for sub32_serial.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sub32_serial;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        bin   = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bout;
  logic        ovf;

  sub32_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Drive operands with start, hold through one rising edge, then release.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic bv_in);
    a     = av;
    b     = bv;
    bin   = bv_in;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges after acceptance until done is seen; 0 means the bound expired.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] ed, input logic eb, input logic eo);
    chk({tag, ".d"}, {32'h0, d}, {32'h0, ed});
    chk({tag, ".bout"}, {63'h0, bout}, {63'h0, eb});
    chk({tag, ".ovf"}, {63'h0, ovf}, {63'h0, eo});
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic [32:0] full;
    logic [31:0] ra, rb, rd;
    logic        rbin, rov;

    vt[0] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'hFFFE0000, 1'b0, 1'b0};
    vt[1] = '{32'd2017701177, 32'd1701853, 1'b0, 32'd2015999324, 1'b0, 1'b0};
    vt[2] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[4] = '{32'hFFABCEDC, 32'hEF821EDA, 1'b1, 32'h1029B001, 1'b0, 1'b0};
    vt[5] = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vt[7] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vt[8] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0};
    vt[9] = '{32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};

    #12;
    chk("reset.busy", {63'h0, busy}, 64'h0);
    chk("reset.done", {63'h0, done}, 64'h0);
    check_res("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: each op checked for latency, result, and a single-cycle done.
    for (int i = 0; i < 10; i++) begin
      launch(vt[i].a, vt[i].b, vt[i].bin);
      chk($sformatf("v%0d.busy", i), {63'h0, busy}, 64'h1);
      wait_done(lat);
      chk($sformatf("v%0d.lat", i), 64'(lat), 64'd4);
      chk($sformatf("v%0d.busy_at_done", i), {63'h0, busy}, 64'h0);
      check_res($sformatf("v%0d", i), vt[i].d, vt[i].bout, vt[i].ovf);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.done_fall", i), {63'h0, done}, 64'h0);
      check_res($sformatf("v%0d.hold", i), vt[i].d, vt[i].bout, vt[i].ovf);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    launch(32'h0, 32'h1, 1'b0);
    wait_done(lat);
    chk("b2b1.lat", 64'(lat), 64'd4);
    check_res("b2b1", 32'hFFFFFFFF, 1'b1, 1'b0);
    launch(32'h80000000, 32'h1, 1'b0);
    chk("b2b2.done_fall", {63'h0, done}, 64'h0);
    chk("b2b2.busy", {63'h0, busy}, 64'h1);
    check_res("b2b2.hold_prev", 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_done(lat);
    chk("b2b2.lat", 64'(lat), 64'd4);
    check_res("b2b2", 32'h7FFFFFFF, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Start while busy must be ignored.
    launch(32'hFFFF0000, 32'h0000FFFF, 1'b1);
    @(posedge clk);
    #1;
    a     = 32'h11111111;
    b     = 32'h22222222;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int n = 3; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("ign.lat", 64'(lat), 64'd4);
    check_res("ign", 32'hFFFE0000, 1'b0, 1'b0);
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("ign.no_second_done", 64'(ndone), 64'd0);
    chk("ign.idle", {63'h0, busy}, 64'h0);

    // Asynchronous reset two clocks into RUN.
    launch(32'h80000000, 32'h1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.busy", {63'h0, busy}, 64'h0);
    chk("rst.done", {63'h0, done}, 64'h0);
    check_res("rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("rst.no_done", 64'(ndone), 64'd0);
    launch(32'hFFABCEDC, 32'hEF821EDA, 1'b1);
    wait_done(lat);
    chk("post_rst.lat", 64'(lat), 64'd4);
    check_res("post_rst", 32'h1029B001, 1'b0, 1'b0);

    // Random sweep against A - B - Bin, issued back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = (i % 8 == 0) ? ra : $urandom;
      rbin = (i % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {32'h0, rbin};
      rd   = full[31:0];
      rov  = (ra[31] != rb[31]) && (rd[31] != ra[31]);
      launch(ra, rb, rbin);
      wait_done(lat);
      chk($sformatf("rnd%0d.lat", i), 64'(lat), 64'd4);
      chk($sformatf("rnd%0d.res a=%h b=%h bin=%0d", i, ra, rb, rbin),
          {30'h0, ovf, bout, d}, {30'h0, rov, full[32], rd});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
